alu_n_bit_stream: RTL and testbench
===================================

Name: alu_n_bit_stream

Overview:
- Parametrised-width ALU with a valid/ready handshake on both sides and a registered output.
- Same 16-opcode set as the team's combinational 8-bit ALU. Divide and modulo run on an iterative restoring divider (multi-cycle), so the block is not combinational.
- Adds Zero and Divide-by-Zero status outputs and a single-entry output buffer with backpressure.
- Sits between an instruction/operand source and a result consumer in datapath blocks.

Parameters:
- DATA_WIDTH, 8, operand and result width in bits; legal range 2 to 32.

Ports:
- Clock_In  in  1  single clock; all state updates on rising edge.
- Reset_In  in  1  asynchronous, active-high reset.
- Valid_In  in  1  operand/opcode presented.
- Ready_Out  out  1  block can accept an operation this cycle.
- ALU_Operation_Select_In  in  4  opcode; encoding in Behaviour.
- Data_A_In  in  DATA_WIDTH  operand A, unsigned.
- Data_B_In  in  DATA_WIDTH  operand B, unsigned.
- Valid_Out  out  1  result registers hold a valid result.
- Ready_In  in  1  consumer accepts the result.
- Result_Out  out  DATA_WIDTH  result.
- Carry_Out  out  1  carry, borrow or overflow per opcode.
- Zero_Out  out  1  Result_Out equals 0.
- Div_By_Zero_Out  out  1  opcode 6 or 7 issued with B equal to 0.
- Busy_Out  out  1  divider iterating.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - Valid_Out, Result_Out, Carry_Out, Zero_Out, Div_By_Zero_Out and Busy_Out all go to 0.
  - Ready_Out goes to 1 after reset deasserts.
  - Reset during DIVIDE aborts the operation; no result is produced.
- Accept rule: an operation is accepted on a rising edge where Valid_In && Ready_Out. Inputs are sampled only at acceptance.
- Ready_Out = (state == IDLE) && (!Valid_Out || Ready_In). It is combinational, and a new operation may be accepted in the same cycle the previous result is consumed.
- Output register:
  - Valid_Out clears on Ready_In && Valid_Out, unless a new result loads in the same edge.
  - While Valid_Out && !Ready_In, all result outputs hold stable.
- State machine:
  - IDLE: non-divide accept loads the result on that edge, so latency is 1 and the state stays IDLE.
  - IDLE: divide accept with B == 0 also loads on that edge (latency 1).
  - IDLE: divide accept with B != 0 goes to DIVIDE; Busy_Out = 1.
  - DIVIDE: one restoring step per cycle for DATA_WIDTH cycles.
  - DIVIDE completion: on the final step edge the result is loaded, Valid_Out = 1, Busy_Out = 0 and the state returns to IDLE. Total latency is DATA_WIDTH+1 edges after acceptance.
  - DIVIDE is entered only when the output buffer is free or being drained, so completion never overwrites an unconsumed result.
- Opcodes (W = DATA_WIDTH; {Carry_Out, Result_Out} is a W+1-bit result unless stated):
  - 0: A+1.
  - 1: A-1 (Carry = borrow, i.e. 1 when A == 0).
  - 2: A+B.
  - 3: A-B (Carry = 1 when A<B).
  - 4: B-A (Carry = 1 when B<A).
  - 5: A*B. Result = low W bits; Carry = 1 if any bit of the upper W bits of the 2W product is set.
  - 6: A/B (quotient), Carry = 0.
  - 7: A%B (remainder), Carry = 0.
  - 8 to F: AND, OR, NOT A, NOT B, NAND, NOR, XOR, XNOR on W bits; Carry = 0.
- Divide by zero: opcode 6 gives Result = all ones; opcode 7 gives Result = A; both give Carry = 0 and Div_By_Zero_Out = 1. Div_By_Zero_Out is 0 for every other result.
- Zero_Out is computed from the loaded Result_Out and registered with it.
- Valid_In while Ready_Out == 0 is ignored; the source must hold it.

Test Plan:
- W=8, op 2, A=0xF0, B=0x20, Ready_In=1 -> next edge: Valid_Out=1, Result=0x10, Carry=1, Zero=0.
- op 3, A=0x10, B=0x20 -> Result=0xF0, Carry=1. Then op 5, A=0x10, B=0x20 -> Result=0x00, Carry=1, Zero=1.
- op 6 then op 7, A=200, B=7 -> Busy_Out high 8 cycles, Ready_Out low throughout. Valid_Out 9 edges after accept: quotient 28 (0x1C), then remainder 4; Carry=0.
- op 6, A=0x55, B=0 -> 1-cycle latency, Result=0xFF, Div_By_Zero=1. op 7 with the same operands -> Result=0x55, Div_By_Zero=1.
- Backpressure: Ready_In=0, issue op 8 (A=0xCC, B=0xAA) -> Result=0x88 held, Ready_Out=0. A second op is ignored until Ready_In=1. Back-to-back accept and drain then sustains 1 op/cycle.
- Reset_In pulsed at cycle 3 of a divide -> all outputs 0 immediately. No Valid_Out follows. Next op 0, A=0xFF -> Result=0x00, Carry=1, Zero=1.

Source files
------------

// File: rtl/alu_n_bit_stream.sv
// Streaming N-bit ALU: 16 opcodes, one-entry registered result buffer with
// backpressure, and an iterative restoring divider for opcodes 6 and 7.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Upstream (Valid_In/Ready_Out) operands are sampled only on that edge.
// Upstream must hold Valid_In and its operands until they are accepted.
// Downstream (Valid_Out/Ready_In) result outputs stay stable while
// Valid_Out && !Ready_In.
module alu_n_bit_stream #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Valid_In,
    output logic                  Ready_Out,
    input  logic [3:0]            ALU_Operation_Select_In,
    input  logic [DATA_WIDTH-1:0] Data_A_In,
    input  logic [DATA_WIDTH-1:0] Data_B_In,
    output logic                  Valid_Out,
    input  logic                  Ready_In,
    output logic [DATA_WIDTH-1:0] Result_Out,
    output logic                  Carry_Out,
    output logic                  Zero_Out,
    output logic                  Div_By_Zero_Out,
    output logic                  Busy_Out,
    output logic                  state_dbg
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic {IDLE = 1'b0, DIVIDE = 1'b1} state_t;

    state_t         state, state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]   rem_q, quo_q, dvs_q;
    logic           mod_q;

    logic           accept, is_div, div_start, load_now, div_done;
    logic [W:0]     shifted, trial;
    logic           fits;
    logic [W-1:0]   rem_nxt, quo_nxt, div_res;

    logic [W-1:0]   alu_res;
    logic           alu_carry, alu_dbz;
    logic [W:0]     wide;
    logic [2*W-1:0] prod;

    // Upstream acceptance: only in IDLE, and only when the result slot is free or draining.
    assign Ready_Out = !Reset_In && (state == IDLE) && (!Valid_Out || Ready_In);
    assign accept    = Valid_In && Ready_Out;
    assign is_div    = (ALU_Operation_Select_In[3:1] == 3'b011);
    assign div_start = accept && is_div && (Data_B_In != '0);
    assign load_now  = accept && !div_start;
    assign div_done  = (state == DIVIDE) && (cnt_q == CNT_W'(DATA_WIDTH - 1));
    assign Busy_Out  = (state == DIVIDE);
    assign state_dbg = (state == DIVIDE);

    // State register.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: enter DIVIDE on a nonzero-divisor divide, leave after the last step.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (div_start) state_nxt = DIVIDE;
            DIVIDE:  if (div_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract if the divisor fits.
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        trial   = shifted - {1'b0, dvs_q};
        fits    = !trial[W];
        rem_nxt = fits ? trial[W-1:0] : shifted[W-1:0];
        quo_nxt = {quo_q[W-2:0], fits};
        div_res = mod_q ? rem_nxt : quo_nxt;
    end

    // Divider datapath: load operands at start, iterate one bit per cycle.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            mod_q <= 1'b0;
        end else if (div_start) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= Data_A_In;
            dvs_q <= Data_B_In;
            mod_q <= ALU_Operation_Select_In[0];
        end else if (state == DIVIDE) begin
            cnt_q <= cnt_q + 1'b1;
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

    // Single-cycle opcodes, plus the divide-by-zero results for 6 and 7.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_dbz   = 1'b0;
        wide      = '0;
        prod      = {{W{1'b0}}, Data_A_In} * {{W{1'b0}}, Data_B_In};
        case (ALU_Operation_Select_In)
            4'h0: begin
                wide = {1'b0, Data_A_In} + {{W{1'b0}}, 1'b1};
                alu_res = wide[W-1:0]; alu_carry = wide[W];
            end
            4'h1: begin
                wide = {1'b0, Data_A_In} - {{W{1'b0}}, 1'b1};
                alu_res = wide[W-1:0]; alu_carry = wide[W];
            end
            4'h2: begin
                wide = {1'b0, Data_A_In} + {1'b0, Data_B_In};
                alu_res = wide[W-1:0]; alu_carry = wide[W];
            end
            4'h3: begin
                wide = {1'b0, Data_A_In} - {1'b0, Data_B_In};
                alu_res = wide[W-1:0]; alu_carry = wide[W];
            end
            4'h4: begin
                wide = {1'b0, Data_B_In} - {1'b0, Data_A_In};
                alu_res = wide[W-1:0]; alu_carry = wide[W];
            end
            4'h5: begin
                alu_res = prod[W-1:0]; alu_carry = |prod[2*W-1:W];
            end
            4'h6: begin
                alu_res = '1; alu_dbz = 1'b1;
            end
            4'h7: begin
                alu_res = Data_A_In; alu_dbz = 1'b1;
            end
            4'h8: alu_res = Data_A_In & Data_B_In;
            4'h9: alu_res = Data_A_In | Data_B_In;
            4'hA: alu_res = ~Data_A_In;
            4'hB: alu_res = ~Data_B_In;
            4'hC: alu_res = ~(Data_A_In & Data_B_In);
            4'hD: alu_res = ~(Data_A_In | Data_B_In);
            4'hE: alu_res = Data_A_In ^ Data_B_In;
            4'hF: alu_res = ~(Data_A_In ^ Data_B_In);
            default: alu_res = '0;
        endcase
    end

    // Result buffer: load on immediate accept or divider completion, else drain.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            Valid_Out       <= 1'b0;
            Result_Out      <= '0;
            Carry_Out       <= 1'b0;
            Zero_Out        <= 1'b0;
            Div_By_Zero_Out <= 1'b0;
        end else if (load_now) begin
            Valid_Out       <= 1'b1;
            Result_Out      <= alu_res;
            Carry_Out       <= alu_carry;
            Zero_Out        <= (alu_res == '0);
            Div_By_Zero_Out <= alu_dbz;
        end else if (div_done) begin
            Valid_Out       <= 1'b1;
            Result_Out      <= div_res;
            Carry_Out       <= 1'b0;
            Zero_Out        <= (div_res == '0);
            Div_By_Zero_Out <= 1'b0;
        end else if (Valid_Out && Ready_In) begin
            Valid_Out       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_n_bit_stream.sv
// Testbench for alu_n_bit_stream at DATA_WIDTH = 8: directed scenarios plus a
// randomized stream with random backpressure, checked against a reference model.
module tb_alu_n_bit_stream;

  localparam int W = 8;

  logic         Clock_In, Reset_In, Valid_In, Ready_Out, Valid_Out, Ready_In;
  logic [3:0]   ALU_Operation_Select_In;
  logic [W-1:0] Data_A_In, Data_B_In, Result_Out;
  logic         Carry_Out, Zero_Out, Div_By_Zero_Out, Busy_Out, state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] mon_e;
  bit rand_done;

  alu_n_bit_stream #(.DATA_WIDTH(W)) dut (
    .Clock_In(Clock_In), .Reset_In(Reset_In), .Valid_In(Valid_In), .Ready_Out(Ready_Out),
    .ALU_Operation_Select_In(ALU_Operation_Select_In), .Data_A_In(Data_A_In),
    .Data_B_In(Data_B_In), .Valid_Out(Valid_Out), .Ready_In(Ready_In),
    .Result_Out(Result_Out), .Carry_Out(Carry_Out), .Zero_Out(Zero_Out),
    .Div_By_Zero_Out(Div_By_Zero_Out), .Busy_Out(Busy_Out), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  initial begin
    Clock_In = 1'b0;
    forever #5 Clock_In = ~Clock_In;
  end
  always @(posedge Clock_In) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input longint unsigned got, input longint unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: {div_by_zero, carry, result} from plain arithmetic.
  function automatic logic [W+1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned la, lb, mask, r;
    bit c, dz;
    la = a; lb = b; mask = (64'd1 << W) - 1;
    c = 0; dz = 0; r = 0;
    case (op)
      4'h0: begin r = la + 1;   c = (r > mask); end
      4'h1: begin r = la - 1;   c = (la == 0);  end
      4'h2: begin r = la + lb;  c = (r > mask); end
      4'h3: begin r = la - lb;  c = (la < lb);  end
      4'h4: begin r = lb - la;  c = (lb < la);  end
      4'h5: begin r = la * lb;  c = ((r >> W) != 0); end
      4'h6: if (lb == 0) begin r = mask; dz = 1; end else r = la / lb;
      4'h7: if (lb == 0) begin r = la;   dz = 1; end else r = la % lb;
      4'h8: r = la & lb;
      4'h9: r = la | lb;
      4'hA: r = ~la;
      4'hB: r = ~lb;
      4'hC: r = ~(la & lb);
      4'hD: r = ~(la | lb);
      4'hE: r = la ^ lb;
      default: r = ~(la ^ lb);
    endcase
    r = r & mask;
    return {dz, c, r[W-1:0]};
  endfunction

  // scoreboard: every consumed result is compared against the oldest expectation
  always @(negedge Clock_In) begin
    if (!Reset_In && Valid_Out && Ready_In) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("result", Result_Out, mon_e[W-1:0]);
        check_val("carry", Carry_Out, mon_e[W]);
        check_val("zero", Zero_Out, (mon_e[W-1:0] == '0));
        check_val("dbz", Div_By_Zero_Out, mon_e[W+1]);
      end
    end
  end

  // driver: present an op and hold it until accepted; returns 1 time unit after the accept edge
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    bit ok;
    n = 0; ok = 0;
    Valid_In = 1'b1;
    ALU_Operation_Select_In = op;
    Data_A_In = a;
    Data_B_In = b;
    while (!ok && n < 200) begin
      @(negedge Clock_In);
      if (Ready_Out) ok = 1;
      else n++;
    end
    if (!ok) begin
      check_val("accept_timeout", 0, 1);
    end else begin
      @(posedge Clock_In);
      exp_q.push_back(model(op, a, b));
      #1;
    end
    Valid_In = 1'b0;
  endtask

  // latency (accept edge counts as 1) and busy-cycle count until Valid_Out rises
  task automatic wait_valid(output int lat, output int busy_n);
    lat = 1; busy_n = 0;
    while (!Valid_Out && lat < 100) begin
      if (Busy_Out) begin
        busy_n++;
        check_val("ready_while_busy", Ready_Out, 0);
      end
      @(posedge Clock_In);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bn, c0, seen;
    logic [3:0] op;
    logic [W-1:0] a, b;

    Reset_In = 1'b1; Valid_In = 1'b0; Ready_In = 1'b1;
    ALU_Operation_Select_In = '0; Data_A_In = '0; Data_B_In = '0;
    rand_done = 0;

    // reset state
    repeat (3) @(posedge Clock_In);
    @(negedge Clock_In);
    check_val("rst_valid", Valid_Out, 0);
    check_val("rst_result", Result_Out, 0);
    check_val("rst_carry", Carry_Out, 0);
    check_val("rst_zero", Zero_Out, 0);
    check_val("rst_dbz", Div_By_Zero_Out, 0);
    check_val("rst_busy", Busy_Out, 0);
    Reset_In = 1'b0;
    #1;
    check_val("ready_after_reset", Ready_Out, 1);
    @(posedge Clock_In); #1;

    // directed single-cycle ops
    issue(4'h2, 8'hF0, 8'h20); wait_valid(lat, bn); check_val("lat_add", lat, 1);
    issue(4'h3, 8'h10, 8'h20); wait_valid(lat, bn); check_val("lat_sub", lat, 1);
    issue(4'h5, 8'h10, 8'h20); wait_valid(lat, bn); check_val("lat_mul", lat, 1);

    // multi-cycle divide and modulo
    issue(4'h6, 8'd200, 8'd7); wait_valid(lat, bn);
    check_val("lat_div", lat, W + 1);
    check_val("busy_div", bn, W);
    issue(4'h7, 8'd200, 8'd7); wait_valid(lat, bn);
    check_val("lat_mod", lat, W + 1);
    check_val("busy_mod", bn, W);

    // divide by zero completes in one cycle
    issue(4'h6, 8'h55, 8'h00); wait_valid(lat, bn); check_val("lat_div0", lat, 1);
    issue(4'h7, 8'h55, 8'h00); wait_valid(lat, bn); check_val("lat_mod0", lat, 1);

    // backpressure: result held, second op not accepted until drained
    @(posedge Clock_In); #1;
    Ready_In = 1'b0;
    issue(4'h8, 8'hCC, 8'hAA); wait_valid(lat, bn); check_val("lat_and", lat, 1);
    Valid_In = 1'b1; ALU_Operation_Select_In = 4'h2; Data_A_In = 8'h01; Data_B_In = 8'h02;
    repeat (3) begin
      @(negedge Clock_In);
      check_val("bp_ready", Ready_Out, 0);
      check_val("bp_valid", Valid_Out, 1);
      check_val("bp_hold", Result_Out, 8'h88);
    end
    @(posedge Clock_In); #1;
    Ready_In = 1'b1;
    issue(4'h2, 8'h01, 8'h02);

    // back-to-back single-cycle ops sustain one per cycle
    @(posedge Clock_In); #1;
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'h6 || op == 4'h7) op = 4'hE;
      issue(op, 8'($urandom), 8'($urandom));
    end
    check_val("throughput_cycles", cyc - c0, 16);

    // randomized stream with random backpressure
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          op = 4'($urandom_range(0, 15));
          a  = 8'($urandom);
          b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge Clock_In); #1;
          end
          issue(op, a, b);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge Clock_In); #1;
          Ready_In = ($urandom_range(0, 9) < 7);
        end
      end
    join
    Ready_In = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || Valid_Out); i++) begin
      @(posedge Clock_In); #1;
    end
    check_val("drain_empty", exp_q.size(), 0);

    // reset during divide aborts it
    @(posedge Clock_In); #1;
    issue(4'h6, 8'd200, 8'd7);
    repeat (2) begin
      @(posedge Clock_In); #1;
    end
    check_val("busy_before_abort", Busy_Out, 1);
    Reset_In = 1'b1;
    #1;
    check_val("abort_valid", Valid_Out, 0);
    check_val("abort_result", Result_Out, 0);
    check_val("abort_carry", Carry_Out, 0);
    check_val("abort_zero", Zero_Out, 0);
    check_val("abort_dbz", Div_By_Zero_Out, 0);
    check_val("abort_busy", Busy_Out, 0);
    exp_q.delete();
    @(posedge Clock_In); #1;
    Reset_In = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge Clock_In);
      if (Valid_Out || Busy_Out) seen++;
    end
    check_val("no_result_after_abort", seen, 0);
    @(posedge Clock_In); #1;
    issue(4'h0, 8'hFF, 8'h00); wait_valid(lat, bn); check_val("lat_inc", lat, 1);
    repeat (3) @(posedge Clock_In);
    #1;
    check_val("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
